// File: rtl/sample_expand_arbiter.sv
// rtl/sample_expand_arbiter.sv - round-robin arbiter feeding one shared sign-extender into a result register
// signed_expand is the shared datapath; sample_expand_arbiter schedules channels onto it.

module signed_expand #(
  parameter int operand_size   = 12,
  parameter int expansion_size = 4
) (
  input  logic [operand_size-1:0]                operand,
  output logic [operand_size+expansion_size-1:0] expanded
);
  assign expanded = {{expansion_size{operand[operand_size-1]}}, operand};
endmodule

module sample_expand_arbiter #(
  parameter int N_CH           = 2,
  parameter int operand_size   = 12,
  parameter int expansion_size = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [N_CH-1:0]                        req_valid,
  input  logic [N_CH*operand_size-1:0]           req_data,
  output logic [N_CH-1:0]                        req_ready,
  output logic                                   out_valid,
  output logic [operand_size+expansion_size-1:0] out_data,
  output logic [$clog2(N_CH)-1:0]                out_ch,
  input  logic                                   out_ready
);
  localparam int CW = $clog2(N_CH);
  localparam int OW = operand_size + expansion_size;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           rr_ptr;
  logic [CW-1:0]           grant;
  logic                    grant_vld;
  logic                    can_load;
  logic                    take;
  logic [operand_size-1:0] grant_sample;
  logic [OW-1:0]           grant_expanded;

  // Walk downward from the farthest offset so the requester nearest rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    for (int k = N_CH-1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % N_CH]) begin
        grant_vld = 1'b1;
        grant     = CW'((int'(rr_ptr) + k) % N_CH);
      end
    end
  end

  assign can_load = (state == EMPTY) || out_ready;
  assign take     = rst_n && can_load && grant_vld;

  always_comb begin
    req_ready = '0;
    if (take) req_ready[grant] = 1'b1;
  end

  // Only the granted slice is selected, so junk on idle channels cannot leak.
  assign grant_sample = req_data[int'(grant)*operand_size +: operand_size];

  signed_expand #(
    .operand_size   (operand_size),
    .expansion_size (expansion_size)
  ) u_expand (
    .operand  (grant_sample),
    .expanded (grant_expanded)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (take) state_nxt = FULL;
      FULL:    if (out_ready && !take) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  assign out_valid = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_ch   <= '0;
      rr_ptr   <= '0;
    end else if (take) begin
      out_data <= grant_expanded;
      out_ch   <= grant;
      if (int'(grant) == N_CH-1) rr_ptr <= '0;
      else                       rr_ptr <= grant + 1'b1;
    end
  end
endmodule

// File: tb/tb_sample_expand_arbiter.sv
// tb/tb_sample_expand_arbiter.sv - scoreboard bench for sample_expand_arbiter

module tb_sample_expand_arbiter;
  localparam int N_CH = 2;
  localparam int OPW  = 12;
  localparam int EXW  = 4;
  localparam int OW   = OPW + EXW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_CH-1:0]  req_valid = '0;
  logic [N_CH*OPW-1:0] req_data = '0;
  logic [N_CH-1:0]  req_ready;
  logic             out_valid;
  logic [OW-1:0]    out_data;
  logic [0:0]       out_ch;
  logic             out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [OW:0] sb_q[$];
  int          m_ptr  = 0;
  logic        m_full = 1'b0;

  sample_expand_arbiter #(.N_CH(N_CH), .operand_size(OPW), .expansion_size(EXW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] sext(input logic [OPW-1:0] v);
    logic signed [OPW-1:0] s;
    logic signed [OW-1:0]  r;
    s = v;
    r = s;
    return r;
  endfunction

  // Check outputs at the falling edge, predict the upcoming rising edge, then step past it.
  task automatic cycle();
    int          g;
    logic        cl;
    logic [N_CH-1:0] er;
    logic [OW:0] e;
    @(negedge clk);
    check("out_valid", out_valid, m_full);
    if (m_full && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("out_data", out_data, e[OW-1:0]);
        check("out_ch", out_ch, e[OW]);
      end
    end
    g = -1;
    for (int k = 0; k < N_CH; k++) begin
      int idx;
      idx = (m_ptr + k) % N_CH;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    cl = !m_full || out_ready;
    er = '0;
    if (cl && g >= 0) er[g] = 1'b1;
    check("req_ready", req_ready, er);
    if (cl && g >= 0) begin
      sb_q.push_back({1'(g), sext(req_data[g*OPW +: OPW])});
      m_ptr  = (g + 1) % N_CH;
      m_full = 1'b1;
    end else if (out_ready) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [OPW-1:0] v);
    req_data[ch*OPW +: OPW] = v;
  endtask

  initial begin
    // 1: reset then idle
    #12;
    check("rst_req_ready", req_ready, 0);
    check("rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    check("idle_out_data", out_data, 16'h0000);

    // 2: extension boundaries on ch0
    out_ready = 1'b1;
    req_valid = 2'b01;
    set_ch(0, 12'h7FF); cycle();
    check("max_pos", out_data, 16'h07FF);
    check("max_pos_ch", out_ch, 0);
    set_ch(0, 12'h800); cycle();
    check("max_neg", out_data, 16'hF800);
    set_ch(0, 12'hFFF); cycle();
    check("minus1", out_data, 16'hFFFF);

    // 3: both channels continuously
    set_ch(0, 12'h123); set_ch(1, 12'h9AB);
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) cycle();

    // 4: stall with 0123 held, then release
    req_valid = 2'b00; cycle();
    req_valid = 2'b01; cycle();
    check("hold_load", out_data, 16'h0123);
    req_valid = 2'b11;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_data", out_data, 16'h0123);
      check("stall_ch", out_ch, 0);
    end
    out_ready = 1'b1;
    cycle();
    check("post_stall", out_data, 16'hF9AB);

    // 5: ch1 alone, then both -> ch0 first
    req_valid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      set_ch(1, 12'(i * 300 + 7));
      cycle();
    end
    req_valid = 2'b11;
    cycle();
    check("after_ch1_only", out_ch, 0);
    cycle();

    // random mix with random backpressure
    for (int i = 0; i < 60; i++) begin
      req_valid = N_CH'($urandom_range(0, 3));
      set_ch(0, 12'($urandom)); set_ch(1, 12'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // 6: async reset mid-burst
    out_ready = 1'b1;
    req_valid = 2'b11;
    set_ch(0, 12'h456); set_ch(1, 12'hBCD);
    cycle(); cycle(); cycle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_req_ready", req_ready, 0);
    check("async_out_data", out_data, 0);
    sb_q.delete();
    m_full = 1'b0;
    m_ptr  = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();
    check("first_after_rst_ch", out_ch, 0);
    check("first_after_rst", out_data, 16'h0456);
    cycle();

    // drain
    req_valid = 2'b00;
    cycle(); cycle();
    check("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
